alu_mb_sequencer: RTL and testbench
===================================

# alu_mb_sequencer

Multi-byte arithmetic sequencer in front of the 8-bit combinational `ALU` (ports A, B, SEL[4:0], Z, Cout). It accepts an NBYTES-wide command over a valid/ready handshake and drives the ALU one byte per cycle, LSB first, chaining carry/borrow through the ALU's carry-in opcodes. It then returns the full-width result and final carry over a second valid/ready handshake. It sits between a command source (bench or controller) and one `ALU` instance.

## Interface
- `NBYTES`, 2, operand width in bytes; legal range 2..8.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  3  000 PASSA, 001 PASSB, 010 AND, 011 OR, 100 SUB, 101 ADD, 110 INC (A+1), 111 reserved.
- `cmd_a`, `cmd_b`  in  8*NBYTES  operands.
- `res_valid`  out  1  result present.
- `res_ready`  in  1  consumer accepts result.
- `res_z`  out  8*NBYTES  result.
- `res_cout`  out  1  final carry (ADD/INC) or borrow (SUB); 0 otherwise.
- `alu_a`, `alu_b`  out  8  byte operands to ALU.
- `alu_sel`  out  5  ALU opcode.
- `alu_z`  in  8  ALU result.
- `alu_cout`  in  1  ALU carry out (borrow for SUB codes).

## Operation
- FSM with three states: IDLE, RUN, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch op, A and B, clear idx and carry, clear the result register, and go to RUN.
- RUN: drive `alu_a`/`alu_b` with byte idx of the latched operands. Each edge writes `alu_z` into result byte idx and loads carry from `alu_cout` (forced 0 for PASSA/PASSB/AND/OR/reserved). Then idx++. At idx==NBYTES-1, go to DONE.
- DONE: `res_valid`=1 with `res_z`/`res_cout` stable. On `res_ready`, go to IDLE.
- SEL per byte:
  - PASSA 00000; PASSB 00001; AND 00010; OR 00011.
  - ADD: byte 0 uses 00101. Byte i>0 uses 00111 if carry, else 00101.
  - SUB: byte 0 uses 00100. Byte i>0 uses 01000 if borrow, else 00100. ALU Cout=1 means borrow.
  - INC: byte 0 uses 00110. Byte i>0 uses 00110 if carry, else 00000 (pass A).
  - Reserved: 11111 every byte, giving Z=0.
- `res_cout` equals carry after the last byte.
- Outside RUN: `alu_a`=`alu_b`=0 and `alu_sel`=11111.
- No new command is accepted while in RUN or DONE.

## Timing
- Reset values: `cmd_ready`=0 during the `rst` cycle and 1 afterward (state IDLE). `res_valid`=0, `res_z`=0, `res_cout`=0, `alu_sel`=11111, `alu_a`=`alu_b`=0.
- The ALU is combinational. The byte result is captured on the same edge that advances idx.
- Command accepted at edge t. RUN occupies cycles t+1..t+NBYTES. `res_valid` rises after edge t+NBYTES.
- Minimum command-to-command spacing is NBYTES+2 cycles with `res_ready` held high.
- Result handshake completes on the edge where `res_valid`&&`res_ready`. `cmd_ready` rises the following cycle, so there is no same-cycle result/command overlap.
- `rst` in any state, including mid-RUN or in DONE with `res_ready` low: return to IDLE next edge and clear all outputs to reset values. The in-flight command is dropped.
- Carry/borrow wrap: the full-width result is modulo 2^(8*NBYTES). Overflow or underflow is reported only through `res_cout`.

## Structure
- Shared package `alu_pkg`:
  - op codes (`OP_PASSA`..`OP_INC`, `OP_RSVD`);
  - ALU SEL constants (`SEL_PASSA`=00000 … `SEL_SUBDEC`=01000, `SEL_ZERO`=11111);
  - FSM state enum.
- Single module, no sub-modules. `ALU` is instantiated beside it at the next level up, not inside.

## Test plan
Use NBYTES=2 with a real `ALU` instance for all scenarios.
- ADD 0x00FF+0x0001: `alu_sel` sequence 00101 then 00111 → `res_z`=0x0100, `res_cout`=0. ADD 0xFFFF+0x0001 → 0x0000, `res_cout`=1.
- SUB 0x0100−0x0001: sel 00100 then 01000 → 0x00FF, cout 0. SUB 0x0000−0x0001 → 0xFFFF, cout 1.
- INC 0x00FF: sel 00110, 00110 → 0x0100. INC 0x1234: sel 00110, 00000 → 0x1235, cout 0.
- AND 0x0F0F&0x00FF → 0x000F. OR 0x0300|0x000C → 0x030C. Reserved op → 0x0000, cout 0.
- Backpressure: hold `res_ready`=0 for 5 cycles → `res_valid`=1 and `res_z` stable, `cmd_ready`=0, a presented command is not accepted. Release → IDLE next cycle.
- Assert `rst` during the second RUN cycle of ADD 0xFFFF+0x0001 → next cycle IDLE with all outputs at reset values. A following ADD 0x0001+0x0001 returns 0x0002 with no stale carry.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, ALU select codes and FSM states shared by the multi-byte sequencer
package alu_pkg;
  typedef enum logic [2:0] {
    OP_PASSA, OP_PASSB, OP_AND, OP_OR, OP_SUB, OP_ADD, OP_INC, OP_RSVD
  } op_t;
  localparam logic [4:0] SEL_PASSA  = 5'b00000;
  localparam logic [4:0] SEL_PASSB  = 5'b00001;
  localparam logic [4:0] SEL_AND    = 5'b00010;
  localparam logic [4:0] SEL_OR     = 5'b00011;
  localparam logic [4:0] SEL_SUB    = 5'b00100;
  localparam logic [4:0] SEL_ADD    = 5'b00101;
  localparam logic [4:0] SEL_INC    = 5'b00110;
  localparam logic [4:0] SEL_ADDC   = 5'b00111;
  localparam logic [4:0] SEL_SUBDEC = 5'b01000;
  localparam logic [4:0] SEL_ZERO   = 5'b11111;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic chains(op_t op);
    return op == OP_ADD || op == OP_SUB || op == OP_INC;
  endfunction
  function automatic logic [4:0] sel_for(op_t op, logic first, logic carry);
    return op == OP_PASSA ? SEL_PASSA :
           op == OP_PASSB ? SEL_PASSB :
           op == OP_AND   ? SEL_AND :
           op == OP_OR    ? SEL_OR :
           op == OP_ADD   ? (!first && carry ? SEL_ADDC : SEL_ADD) :
           op == OP_SUB   ? (!first && carry ? SEL_SUBDEC : SEL_SUB) :
           op == OP_INC   ? (first || carry ? SEL_INC : SEL_PASSA) : SEL_ZERO;
  endfunction
endpackage

// File: rtl/alu_mb_sequencer_if.sv
// alu_mb_sequencer_if: command and result handshakes of the multi-byte sequencer
interface alu_mb_sequencer_if
  import alu_pkg::*;
#(parameter int NBYTES = 2);
  logic cmd_valid;
  logic cmd_ready;
  op_t cmd_op;
  logic [8*NBYTES-1:0] cmd_a;
  logic [8*NBYTES-1:0] cmd_b;
  logic res_valid;
  logic res_ready;
  logic [8*NBYTES-1:0] res_z;
  logic res_cout;
  modport master (output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
                  input cmd_ready, res_valid, res_z, res_cout);
  modport slave (input cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
                 output cmd_ready, res_valid, res_z, res_cout);
endinterface

// File: rtl/ALU.sv
// ALU: 8-bit combinational ALU with carry-in opcodes; Cout is borrow for the subtract codes
module ALU
  import alu_pkg::*;
(
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [4:0] SEL,
  output logic [7:0] Z,
  output logic       Cout
);
  logic [8:0] r;
  // ninth bit of r carries the carry, or the borrow for subtraction
  always_comb begin
    r = SEL == SEL_PASSA  ? {1'b0, A} :
        SEL == SEL_PASSB  ? {1'b0, B} :
        SEL == SEL_AND    ? {1'b0, A & B} :
        SEL == SEL_OR     ? {1'b0, A | B} :
        SEL == SEL_SUB    ? {1'b0, A} - {1'b0, B} :
        SEL == SEL_ADD    ? {1'b0, A} + {1'b0, B} :
        SEL == SEL_INC    ? {1'b0, A} + 9'd1 :
        SEL == SEL_ADDC   ? {1'b0, A} + {1'b0, B} + 9'd1 :
        SEL == SEL_SUBDEC ? {1'b0, A} - {1'b0, B} - 9'd1 : 9'd0;
    Z = r[7:0];
    Cout = r[8];
  end
endmodule

// File: rtl/alu_mb_sequencer.sv
// alu_mb_sequencer: runs an NBYTES-wide op through an 8-bit ALU one byte per cycle, LSB first
module alu_mb_sequencer
  import alu_pkg::*;
#(parameter int NBYTES = 2)
(
  input  logic clk,
  input  logic rst,
  alu_mb_sequencer_if.slave bus,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [4:0] alu_sel,
  input  logic [7:0] alu_z,
  input  logic       alu_cout
);
  localparam int W = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  state_t state_q, state_d;
  op_t op_q;
  logic [W-1:0] a_q, b_q, z_q;
  logic [IW-1:0] idx_q;
  logic carry_q;
  logic last;
  assign last = idx_q == IW'(NBYTES - 1);
  // state register
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  // next state, handshakes and the byte slice presented to the ALU
  always_comb begin
    state_d = state_q == IDLE ? (bus.cmd_valid ? RUN : IDLE) :
              state_q == RUN  ? (last ? DONE : RUN) :
              bus.res_ready   ? IDLE : DONE;
    bus.cmd_ready = state_q == IDLE && !rst;
    bus.res_valid = state_q == DONE;
    bus.res_z = z_q;
    bus.res_cout = carry_q;
    alu_a = state_q == RUN ? a_q[{idx_q, 3'b000} +: 8] : 8'd0;
    alu_b = state_q == RUN ? b_q[{idx_q, 3'b000} +: 8] : 8'd0;
    alu_sel = state_q == RUN ? sel_for(op_q, idx_q == '0, carry_q) : SEL_ZERO;
  end
  // latch the command, then collect one result byte and the chained carry per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= OP_PASSA;
      a_q <= '0;
      b_q <= '0;
      z_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
    end else if (state_q == IDLE && bus.cmd_valid) begin
      op_q <= bus.cmd_op;
      a_q <= bus.cmd_a;
      b_q <= bus.cmd_b;
      z_q <= '0;
      idx_q <= '0;
      carry_q <= 1'b0;
    end else if (state_q == RUN) begin
      z_q[{idx_q, 3'b000} +: 8] <= alu_z;
      carry_q <= chains(op_q) && alu_cout;
      idx_q <= idx_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_mb_sequencer.sv
// tb_alu_mb_sequencer: directed table, random ops and corner sequences against an arithmetic model
module tb_alu_mb_sequencer;
  import alu_pkg::*;
  localparam int NB = 2;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] alu_a, alu_b, alu_z;
  logic [4:0] alu_sel;
  logic alu_cout;
  int n_checks = 0;
  int n_fail = 0;
  alu_mb_sequencer_if #(.NBYTES(NB)) bus();
  alu_mb_sequencer #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_z(alu_z), .alu_cout(alu_cout)
  );
  ALU u_alu (.A(alu_a), .B(alu_b), .SEL(alu_sel), .Z(alu_z), .Cout(alu_cout));
  always #5 clk = ~clk;
  typedef struct packed {
    op_t op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] z;
    logic c;
    logic [4:0] s0;
    logic [4:0] s1;
  } vec_t;
  vec_t tbl [12];
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic void model(input op_t op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] z, output logic c);
    logic [16:0] s;
    s = 17'd0;
    case (op)
      OP_PASSA: s = {1'b0, a};
      OP_PASSB: s = {1'b0, b};
      OP_AND:   s = {1'b0, a & b};
      OP_OR:    s = {1'b0, a | b};
      OP_ADD:   s = {1'b0, a} + {1'b0, b};
      OP_SUB:   s = {a < b, a - b};
      OP_INC:   s = {1'b0, a} + 17'd1;
      default:  s = 17'd0;
    endcase
    z = s[15:0];
    c = s[16];
  endfunction
  function automatic logic [4:0] exp_sel(input op_t op, input logic [15:0] a, input logic [15:0] b, input int i);
    int unsigned m, al, bl;
    logic cin;
    m = 32'd1 << (8 * i);
    al = 32'(a) % m;
    bl = 32'(b) % m;
    cin = i > 0 && (op == OP_ADD ? al + bl >= m : op == OP_SUB ? al < bl : op == OP_INC ? al + 1 >= m : 1'b0);
    case (op)
      OP_PASSA: return 5'b00000;
      OP_PASSB: return 5'b00001;
      OP_AND:   return 5'b00010;
      OP_OR:    return 5'b00011;
      OP_ADD:   return cin ? 5'b00111 : 5'b00101;
      OP_SUB:   return cin ? 5'b01000 : 5'b00100;
      OP_INC:   return (i == 0 || cin) ? 5'b00110 : 5'b00000;
      default:  return 5'b11111;
    endcase
  endfunction
  task automatic do_cmd(input op_t op, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] z, output logic c, output logic [4:0] s0, output logic [4:0] s1);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_a = a;
    bus.cmd_b = b;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    s0 = alu_sel;
    @(negedge clk);
    s1 = alu_sel;
    @(negedge clk);
    check("res_valid_latency", 64'(bus.res_valid), 64'd1);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    z = bus.res_z;
    c = bus.res_cout;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    check({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    check({tag, "_res_z"}, 64'(bus.res_z), 64'd0);
    check({tag, "_res_cout"}, 64'(bus.res_cout), 64'd0);
    check({tag, "_alu_sel"}, 64'(alu_sel), 64'h1f);
    check({tag, "_alu_ab"}, 64'({alu_a, alu_b}), 64'd0);
  endtask
  initial begin
    logic [15:0] z, ez, ra, rb;
    logic c, ec;
    logic [4:0] s0, s1;
    op_t rop;
    tbl[0]  = '{OP_ADD,   16'h00FF, 16'h0001, 16'h0100, 1'b0, 5'b00101, 5'b00111};
    tbl[1]  = '{OP_ADD,   16'hFFFF, 16'h0001, 16'h0000, 1'b1, 5'b00101, 5'b00111};
    tbl[2]  = '{OP_SUB,   16'h0100, 16'h0001, 16'h00FF, 1'b0, 5'b00100, 5'b01000};
    tbl[3]  = '{OP_SUB,   16'h0000, 16'h0001, 16'hFFFF, 1'b1, 5'b00100, 5'b01000};
    tbl[4]  = '{OP_INC,   16'h00FF, 16'h0000, 16'h0100, 1'b0, 5'b00110, 5'b00110};
    tbl[5]  = '{OP_INC,   16'h1234, 16'h0000, 16'h1235, 1'b0, 5'b00110, 5'b00000};
    tbl[6]  = '{OP_AND,   16'h0F0F, 16'h00FF, 16'h000F, 1'b0, 5'b00010, 5'b00010};
    tbl[7]  = '{OP_OR,    16'h0300, 16'h000C, 16'h030C, 1'b0, 5'b00011, 5'b00011};
    tbl[8]  = '{OP_RSVD,  16'h1234, 16'h5678, 16'h0000, 1'b0, 5'b11111, 5'b11111};
    tbl[9]  = '{OP_PASSB, 16'h1111, 16'hABCD, 16'hABCD, 1'b0, 5'b00001, 5'b00001};
    tbl[10] = '{OP_PASSA, 16'hBEEF, 16'h2222, 16'hBEEF, 1'b0, 5'b00000, 5'b00000};
    tbl[11] = '{OP_INC,   16'hFFFF, 16'h0000, 16'h0000, 1'b1, 5'b00110, 5'b00110};
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = OP_PASSA;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    for (int i = 0; i < 12; i++) begin
      do_cmd(tbl[i].op, tbl[i].a, tbl[i].b, z, c, s0, s1);
      check($sformatf("vec%0d_z", i), 64'(z), 64'(tbl[i].z));
      check($sformatf("vec%0d_cout", i), 64'(c), 64'(tbl[i].c));
      check($sformatf("vec%0d_sel0", i), 64'(s0), 64'(tbl[i].s0));
      check($sformatf("vec%0d_sel1", i), 64'(s1), 64'(tbl[i].s1));
    end
    for (int i = 0; i < 40; i++) begin
      rop = op_t'($urandom_range(0, 7));
      ra = $urandom_range(0, 3) == 0 ? 16'hFFFF : 16'($urandom);
      rb = $urandom_range(0, 3) == 0 ? 16'h0001 : 16'($urandom);
      model(rop, ra, rb, ez, ec);
      do_cmd(rop, ra, rb, z, c, s0, s1);
      check($sformatf("rnd%0d_z op%0d %h %h", i, rop, ra, rb), 64'(z), 64'(ez));
      check($sformatf("rnd%0d_cout", i), 64'(c), 64'(ec));
      check($sformatf("rnd%0d_sel0", i), 64'(s0), 64'(exp_sel(rop, ra, rb, 0)));
      check($sformatf("rnd%0d_sel1", i), 64'(s1), 64'(exp_sel(rop, ra, rb, 1)));
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_ADD;
    bus.cmd_a = 16'h1234;
    bus.cmd_b = 16'h1111;
    @(posedge clk);
    #1 bus.cmd_op = OP_SUB;
    bus.cmd_a = 16'hAAAA;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp%0d_res_valid", i), 64'(bus.res_valid), 64'd1);
      check($sformatf("bp%0d_res_z", i), 64'(bus.res_z), 64'h2345);
      check($sformatf("bp%0d_cmd_ready", i), 64'(bus.cmd_ready), 64'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(negedge clk);
    check("bp_release_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("bp_release_res_valid", 64'(bus.res_valid), 64'd0);
    check("bp_release_alu_sel", 64'(alu_sel), 64'h1f);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = OP_ADD;
    bus.cmd_a = 16'hFFFF;
    bus.cmd_b = 16'h0001;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrun_sel_byte1", 64'(alu_sel), 64'h07);
    check("midrun_rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrun");
    do_cmd(OP_ADD, 16'h0001, 16'h0001, z, c, s0, s1);
    check("post_rst_z", 64'(z), 64'h0002);
    check("post_rst_cout", 64'(c), 64'd0);
    check("post_rst_sel1", 64'(s1), 64'h05);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
